// File: rtl/dsp48_pkg.sv
// Shared definitions for the DSP48A1 operand register blocks: legal parameter
// ranges, the occupancy-width rule, the parameter legality check and a lane
// slicing helper.
package dsp48_pkg;

  localparam int DEPTH_MIN = 0;
  localparam int DEPTH_MAX = 8;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 48;
  localparam int LANES_MIN = 1;
  localparam int LANES_MAX = 4;

  // Occupancy counter width; never narrower than one bit so DEPTH=0 still has a port.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // True when every parameter lies in its supported range.
  function automatic bit params_legal(input int depth, input int width,
                                      input int lanes, input int gate_data);
    return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX) &&
           (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (lanes >= LANES_MIN) && (lanes <= LANES_MAX) &&
           ((gate_data == 0) || (gate_data == 1));
  endfunction

  // Lowest bit of lane k inside a packed multi-lane bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/dsp_pipe_stage.sv
// One pipeline stage: a DW-bit data register plus its valid bit, with clock
// enable, synchronous clear, async active-low reset and optional data gating.
module dsp_pipe_stage #(
  parameter int DW        = 18,
  parameter int GATE_DATA = 0
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CE,
  input  logic          SCLR,
  input  logic          prev_valid,
  input  logic [DW-1:0] prev_data,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic load_data;

  // With gating, invalid beats leave the data register untouched to save toggles.
  assign load_data = CE && ((GATE_DATA == 0) || prev_valid);

  // Valid bit: clear wins over enable.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      valid <= 1'b0;
    end else if (SCLR) begin
      valid <= 1'b0;
    end else if (CE) begin
      valid <= prev_valid;
    end
  end

  // Data register: cleared together with the valid bit, otherwise loads on load_data.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      data <= '0;
    end else if (SCLR) begin
      data <= '0;
    end else if (load_data) begin
      data <= prev_data;
    end
  end

endmodule

// File: rtl/dsp_pipe_reg.sv
// Multi-lane operand pipeline register: DEPTH clock-enabled stages carrying
// LANES*WIDTH data bits plus a valid bit, with an in-flight occupancy count.
// DEPTH=0 degenerates to a combinational pass-through.
module dsp_pipe_reg
  import dsp48_pkg::*;
#(
  parameter  int DEPTH     = 1,
  parameter  int WIDTH     = 18,
  parameter  int LANES     = 1,
  parameter  int GATE_DATA = 0,
  localparam int DW        = WIDTH * LANES,
  localparam int OCC_W     = occ_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             CE,
  input  logic             SCLR,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic [OCC_W-1:0] occupancy
);

  if (!params_legal(DEPTH, WIDTH, LANES, GATE_DATA)) begin : g_bad_params
    $error("dsp_pipe_reg: DEPTH/WIDTH/LANES/GATE_DATA out of supported range");
  end

  if (DEPTH == 0) begin : g_pass
    // Control inputs are intentionally ignored in pass-through mode.
    logic unused_ctl;
    assign unused_ctl = ^{CLK, RSTN, CE, SCLR};

    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign occupancy = '0;
  end else begin : g_pipe
    logic          stage_valid [0:DEPTH];
    logic [DW-1:0] stage_data  [0:DEPTH];
    logic [OCC_W-1:0] occ;

    assign stage_valid[0] = in_valid;
    assign stage_data[0]  = in_data;

    for (genvar i = 1; i <= DEPTH; i++) begin : g_stage
      dsp_pipe_stage #(
        .DW        (DW),
        .GATE_DATA (GATE_DATA)
      ) u_stage (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .CE         (CE),
        .SCLR       (SCLR),
        .prev_valid (stage_valid[i-1]),
        .prev_data  (stage_data[i-1]),
        .valid      (stage_valid[i]),
        .data       (stage_data[i])
      );
    end

    // Occupancy tracks beats entering minus beats leaving; it cannot exceed DEPTH.
    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        occ <= '0;
      end else if (SCLR) begin
        occ <= '0;
      end else if (CE) begin
        occ <= occ + OCC_W'(in_valid) - OCC_W'(stage_valid[DEPTH]);
      end
    end

    assign out_valid = stage_valid[DEPTH];
    assign out_data  = stage_data[DEPTH];
    assign occupancy = occ;
  end

endmodule

// File: tb/tb_dsp_pipe_reg.sv
// Bench for dsp_pipe_reg: six instances with different DEPTH/LANES/GATE_DATA
// share one set of inputs. A history-of-accepted-beats model predicts outputs.
module tb_dsp_pipe_reg;

  localparam int NI   = 6;
  localparam int HMAX = 16384;
  localparam int DEP [NI] = '{0, 2, 2, 3, 4, 5};
  localparam int GAT [NI] = '{0, 0, 1, 0, 0, 0};
  localparam int DWB [NI] = '{18, 18, 18, 36, 18, 72};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        sclr;
  logic        in_valid;
  logic [71:0] in_data;

  logic ov0, ov1, ov2, ov3, ov4, ov5;
  logic [17:0] od0, od1, od2, od4;
  logic [35:0] od3;
  logic [71:0] od5;
  logic [0:0]  oc0;
  logic [1:0]  oc1, oc2, oc3;
  logic [2:0]  oc4, oc5;

  logic        got_v [NI];
  logic [71:0] got_d [NI];
  logic [3:0]  got_o [NI];

  int errors = 0;
  int checks = 0;

  // Model state: beats accepted since the last clear/reset.
  int          n_acc = 0;
  logic        hv  [HMAX];
  logic [71:0] hd  [HMAX];
  int          hlv [HMAX];

  always #5 clk = ~clk;

  dsp_pipe_reg #(.DEPTH(0), .WIDTH(18), .LANES(1), .GATE_DATA(0)) u_d0 (
    .CLK(clk), .RSTN(rst_n), .CE(ce), .SCLR(sclr), .in_valid(in_valid),
    .in_data(in_data[17:0]), .out_valid(ov0), .out_data(od0), .occupancy(oc0));
  dsp_pipe_reg #(.DEPTH(2), .WIDTH(18), .LANES(1), .GATE_DATA(0)) u_d2 (
    .CLK(clk), .RSTN(rst_n), .CE(ce), .SCLR(sclr), .in_valid(in_valid),
    .in_data(in_data[17:0]), .out_valid(ov1), .out_data(od1), .occupancy(oc1));
  dsp_pipe_reg #(.DEPTH(2), .WIDTH(18), .LANES(1), .GATE_DATA(1)) u_d2g (
    .CLK(clk), .RSTN(rst_n), .CE(ce), .SCLR(sclr), .in_valid(in_valid),
    .in_data(in_data[17:0]), .out_valid(ov2), .out_data(od2), .occupancy(oc2));
  dsp_pipe_reg #(.DEPTH(3), .WIDTH(18), .LANES(2), .GATE_DATA(0)) u_d3 (
    .CLK(clk), .RSTN(rst_n), .CE(ce), .SCLR(sclr), .in_valid(in_valid),
    .in_data(in_data[35:0]), .out_valid(ov3), .out_data(od3), .occupancy(oc3));
  dsp_pipe_reg #(.DEPTH(4), .WIDTH(18), .LANES(1), .GATE_DATA(0)) u_d4 (
    .CLK(clk), .RSTN(rst_n), .CE(ce), .SCLR(sclr), .in_valid(in_valid),
    .in_data(in_data[17:0]), .out_valid(ov4), .out_data(od4), .occupancy(oc4));
  dsp_pipe_reg #(.DEPTH(5), .WIDTH(18), .LANES(4), .GATE_DATA(0)) u_d5 (
    .CLK(clk), .RSTN(rst_n), .CE(ce), .SCLR(sclr), .in_valid(in_valid),
    .in_data(in_data), .out_valid(ov5), .out_data(od5), .occupancy(oc5));

  assign got_v[0] = ov0; assign got_d[0] = 72'(od0); assign got_o[0] = 4'(oc0);
  assign got_v[1] = ov1; assign got_d[1] = 72'(od1); assign got_o[1] = 4'(oc1);
  assign got_v[2] = ov2; assign got_d[2] = 72'(od2); assign got_o[2] = 4'(oc2);
  assign got_v[3] = ov3; assign got_d[3] = 72'(od3); assign got_o[3] = 4'(oc3);
  assign got_v[4] = ov4; assign got_d[4] = 72'(od4); assign got_o[4] = 4'(oc4);
  assign got_v[5] = ov5; assign got_d[5] = 72'(od5); assign got_o[5] = 4'(oc5);

  function automatic logic [71:0] mask_of(input int w);
    logic [71:0] one;
    one = 72'd1;
    return (one << w) - one;
  endfunction

  // A beat accepted as number k reaches the last stage once k+d beats are accepted.
  function automatic logic exp_valid(input int d);
    if (d == 0) return in_valid;
    if (n_acc < d) return 1'b0;
    return hv[n_acc - d];
  endfunction

  // With gating the last stage shows the most recent valid beat that has reached it.
  function automatic logic [71:0] exp_data(input int d, input int g, input int w);
    int k;
    if (d == 0) return in_data & mask_of(w);
    if (n_acc < d) return 72'd0;
    k = n_acc - d;
    if (g == 0) return hd[k] & mask_of(w);
    if (hlv[k] < 0) return 72'd0;
    return hd[hlv[k]] & mask_of(w);
  endfunction

  // Valid beats among the last d accepted ones are exactly those still inside.
  function automatic int exp_occ(input int d);
    int c;
    c = 0;
    for (int i = n_acc - d; i < n_acc; i++)
      if (i >= 0 && hv[i]) c++;
    return c;
  endfunction

  task automatic drive(input logic v, input logic [71:0] d, input logic ce_i,
                       input logic sclr_i);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    ce       = ce_i;
    sclr     = sclr_i;
    @(posedge clk);
    if (rst_n) begin
      if (sclr_i) begin
        n_acc = 0;
      end else if (ce_i) begin
        hv[n_acc]  = v;
        hd[n_acc]  = d;
        hlv[n_acc] = v ? n_acc : ((n_acc > 0) ? hlv[n_acc - 1] : -1);
        n_acc++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; ce = 1'b0; sclr = 1'b0;
    n_acc = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; ce = 1'b0; sclr = 1'b0;
    #12;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (got_v[i] !== 1'b0 || got_d[i] !== 72'd0 || got_o[i] !== 4'd0) begin
        errors++;
        $display("FAIL reset inst%0d got v=%0b d=%h occ=%0d required all zero",
                 i, got_v[i], got_d[i], got_o[i]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    drive(1'b0, 72'd0, 1'b1, 1'b0);
    checks++;
    if (ov5 !== 1'b0 || oc5 !== 3'd0) begin
      errors++;
      $display("FAIL reset_release d5 got v=%0b occ=%0d required 0/0", ov5, oc5);
    end
  endtask

  task automatic test_latency();
    logic [71:0] beats [8];
    do_reset();
    for (int k = 0; k < 8; k++)
      beats[k] = {36'd0, 18'h00ABC + 18'(k), 18'h12345 + 18'(k)};
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, beats[k], 1'b1, 1'b0);
      checks++;
      if (ov3 !== (k >= 2) || od3 !== ((k >= 2) ? beats[k-2][35:0] : 36'd0) ||
          oc3 !== ((k >= 2) ? 2'd3 : 2'(k + 1))) begin
        errors++;
        $display("FAIL latency edge%0d got v=%0b d=%h occ=%0d required v=%0b occ=%0d",
                 k, ov3, od3, oc3, k >= 2, (k >= 2) ? 3 : k + 1);
      end
    end
    #2 rst_n = 1'b0;
    n_acc = 0;
    #1;
    checks++;
    if (ov3 !== 1'b0 || od3 !== 36'd0 || oc3 !== 2'd0 || ov5 !== 1'b0 || oc5 !== 3'd0) begin
      errors++;
      $display("FAIL async_reset got d3 v=%0b d=%h occ=%0d d5 v=%0b occ=%0d required zeros",
               ov3, od3, oc3, ov5, oc5);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 72'd1, 1'b1, 1'b0);
    drive(1'b1, 72'd2, 1'b1, 1'b0);
    checks++;
    if (ov1 !== 1'b1 || od1 !== 18'd1 || oc1 !== 2'd2) begin
      errors++;
      $display("FAIL stall_pre got v=%0b d=%0d occ=%0d required 1/1/2", ov1, od1, oc1);
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 72'd3, 1'b0, 1'b0);
      checks++;
      if (ov1 !== 1'b1 || od1 !== 18'd1 || oc1 !== 2'd2) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%0b d=%0d occ=%0d required 1/1/2",
                 c, ov1, od1, oc1);
      end
    end
    drive(1'b1, 72'd3, 1'b1, 1'b0);
    checks++;
    if (ov1 !== 1'b1 || od1 !== 18'd2 || oc1 !== 2'd2) begin
      errors++;
      $display("FAIL stall_resume got v=%0b d=%0d occ=%0d required 1/2/2", ov1, od1, oc1);
    end
    drive(1'b0, 72'd0, 1'b1, 1'b0);
    checks++;
    if (ov1 !== 1'b1 || od1 !== 18'd3 || oc1 !== 2'd1) begin
      errors++;
      $display("FAIL stall_third got v=%0b d=%0d occ=%0d required 1/3/1", ov1, od1, oc1);
    end
    drive(1'b0, 72'd0, 1'b1, 1'b0);
    checks++;
    if (ov1 !== 1'b0 || oc1 !== 2'd0) begin
      errors++;
      $display("FAIL stall_drain got v=%0b occ=%0d required 0/0", ov1, oc1);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 4; k++) drive(1'b1, 72'(10 + k), 1'b1, 1'b0);
    checks++;
    if (ov4 !== 1'b1 || od4 !== 18'd10 || oc4 !== 3'd4) begin
      errors++;
      $display("FAIL flush_full got v=%0b d=%0d occ=%0d required 1/10/4", ov4, od4, oc4);
    end
    drive(1'b1, 72'd99, 1'b0, 1'b1);
    checks++;
    if (ov4 !== 1'b0 || od4 !== 18'd0 || oc4 !== 3'd0) begin
      errors++;
      $display("FAIL flush_ce0 got v=%0b d=%0d occ=%0d required 0/0/0", ov4, od4, oc4);
    end
    drive(1'b1, 72'd55, 1'b1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (ov4 !== 1'b0 || oc4 !== 3'd0) begin
        errors++;
        $display("FAIL flush_drop%0d got v=%0b occ=%0d required 0/0", c, ov4, oc4);
      end
      drive(1'b0, 72'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_gating();
    do_reset();
    drive(1'b1, 72'h3FFFF, 1'b1, 1'b0);
    drive(1'b0, 72'd1, 1'b1, 1'b0);
    checks++;
    if (ov2 !== 1'b1 || od2 !== 18'h3FFFF || ov1 !== 1'b1 || od1 !== 18'h3FFFF) begin
      errors++;
      $display("FAIL gate_valid got g1 v=%0b d=%h g0 v=%0b d=%h required 1/3ffff both",
               ov2, od2, ov1, od1);
    end
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 72'd1, 1'b1, 1'b0);
      checks++;
      if (ov2 !== 1'b0 || od2 !== 18'h3FFFF) begin
        errors++;
        $display("FAIL gate_on%0d got v=%0b d=%h required 0/3ffff", c, ov2, od2);
      end
      checks++;
      if (ov1 !== 1'b0 || od1 !== 18'h00001) begin
        errors++;
        $display("FAIL gate_off%0d got v=%0b d=%h required 0/00001", c, ov1, od1);
      end
    end
  endtask

  task automatic test_passthrough();
    logic [71:0] d;
    logic v;
    @(negedge clk);
    rst_n = 1'b0; ce = 1'b0; sclr = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 6; c++) begin
      d = 72'({$urandom, $urandom, $urandom});
      v = 1'($urandom_range(0, 1));
      in_data = d; in_valid = v;
      #1;
      checks++;
      if (ov0 !== v || od0 !== d[17:0] || oc0 !== 1'b0) begin
        errors++;
        $display("FAIL passthrough%0d got v=%0b d=%h occ=%0d required v=%0b d=%h occ=0",
                 c, ov0, od0, oc0, v, d[17:0]);
      end
      #1;
    end
    @(negedge clk);
    sclr = 1'b0; in_valid = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic v, c, s;
    logic [71:0] d;
    do_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      v = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 63) == 0);
      d = 72'({$urandom, $urandom, $urandom});
      drive(v, d, c, s);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (got_v[i] !== exp_valid(DEP[i]) ||
            got_d[i] !== exp_data(DEP[i], GAT[i], DWB[i]) ||
            got_o[i] !== 4'(exp_occ(DEP[i]))) begin
          errors++;
          $display("FAIL random cyc%0d inst%0d got v=%0b d=%h occ=%0d required v=%0b d=%h occ=%0d",
                   cyc, i, got_v[i], got_d[i], got_o[i], exp_valid(DEP[i]),
                   exp_data(DEP[i], GAT[i], DWB[i]), exp_occ(DEP[i]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_gating();
    test_passthrough();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
